// File: rtl/pea_pkg.sv
// Shared PE arithmetic parameters and the divider front/back-end FSM encoding.
package pea_pkg;

  localparam int N_BITS      = 32;
  localparam int N_RADIX     = 2;
  localparam int N_DIV_STAGE = N_BITS / $clog2(N_RADIX);

  localparam logic [N_BITS-1:0] MIN_VAL = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } div_ctrl_fsm_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, modulo 2^N_BITS.
module div_sign_fix
  import pea_pkg::*;
(
  input  logic [N_BITS-1:0] in,
  input  logic              neg,
  output logic [N_BITS-1:0] out
);

  function automatic logic [N_BITS-1:0] cond_negate(input logic [N_BITS-1:0] value,
                                                    input logic              flip);
    logic signed [N_BITS-1:0] sval;
    sval = signed'(value);
    return flip ? N_BITS'(-sval) : value;
  endfunction

  assign out = cond_negate(in, neg);

endmodule

// File: rtl/div_op_ctrl.sv
// Operand/result wrapper around the multicycle restoring divider core:
// magnitude conversion, fixed-length core enable sweep, sign fix-up and special cases.
module div_op_ctrl
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              signed_i,
  input  logic              rem_i,
  output logic              core_en_o,
  output logic [N_BITS-1:0] core_n_o,
  output logic [N_BITS-1:0] core_d_o,
  input  logic              core_valid_i,
  input  logic [N_BITS-1:0] core_q_i,
  input  logic [N_BITS-1:0] core_r_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_BITS-1:0] res_o,
  output logic              dbz_o
);

  localparam int CNT_W = (N_DIV_STAGE > 1) ? $clog2(N_DIV_STAGE) : 1;

  if (N_DIV_STAGE < 2 || (N_DIV_STAGE & (N_DIV_STAGE - 1)) != 0) begin : g_stage_check
    $error("N_DIV_STAGE must be a power of two");
  end

  div_ctrl_fsm_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept, last_iter, div_zero, ovf;
  logic              neg_q, neg_r, rem_sel;
  logic [N_BITS-1:0] mag_a, mag_b, q_fix, r_fix;

  assign accept    = in_valid_i & in_ready_o;
  assign last_iter = (cnt == CNT_W'(N_DIV_STAGE - 1));
  assign div_zero  = (b_i == '0);
  assign ovf       = signed_i & (a_i == MIN_VAL) & (b_i == '1);

  div_sign_fix u_abs_a (.in(a_i),      .neg(signed_i & a_i[N_BITS-1]), .out(mag_a));
  div_sign_fix u_abs_b (.in(b_i),      .neg(signed_i & b_i[N_BITS-1]), .out(mag_b));
  div_sign_fix u_fix_q (.in(core_q_i), .neg(neg_q),                    .out(q_fix));
  div_sign_fix u_fix_r (.in(core_r_i), .neg(neg_r),                    .out(r_fix));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    core_en_o   = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = ~rst_i;
        if (accept) state_nxt = (div_zero | ovf) ? DONE : RUN;
      end
      RUN: begin
        core_en_o = 1'b1;
        if (last_iter) state_nxt = WAIT;
      end
      WAIT: begin
        if (core_valid_i) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter wraps to zero after the last iteration since N_DIV_STAGE is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              cnt <= '0;
    else if (state == RUN)  cnt <= cnt + 1'b1;
    else                    cnt <= '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_n_o <= '0;
      core_d_o <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      res_o    <= '0;
      dbz_o    <= 1'b0;
    end else if (accept) begin
      core_n_o <= mag_a;
      core_d_o <= mag_b;
      neg_q    <= signed_i & (a_i[N_BITS-1] ^ b_i[N_BITS-1]);
      neg_r    <= signed_i & a_i[N_BITS-1];
      rem_sel  <= rem_i;
      dbz_o    <= div_zero;
      if (div_zero)  res_o <= rem_i ? a_i : '1;
      else if (ovf)  res_o <= rem_i ? '0 : MIN_VAL;
    end else if (state == WAIT && core_valid_i) begin
      res_o <= rem_sel ? r_fix : q_fix;
    end
  end

endmodule

// File: tb/tb_div_op_ctrl.sv
// Bench for div_op_ctrl: directed vector table, corner sequences and random ops vs. a behavioural model.
module tb_div_op_ctrl;
  import pea_pkg::*;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [N_BITS-1:0] a_i = '0, b_i = '0;
  logic              signed_i = 1'b0, rem_i = 1'b0;
  logic              core_en_o;
  logic [N_BITS-1:0] core_n_o, core_d_o;
  logic              core_valid_i = 1'b0;
  logic [N_BITS-1:0] core_q_i = '0, core_r_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [N_BITS-1:0] res_o;
  logic              dbz_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_op_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .rem_i(rem_i),
    .core_en_o(core_en_o), .core_n_o(core_n_o), .core_d_o(core_d_o),
    .core_valid_i(core_valid_i), .core_q_i(core_q_i), .core_r_i(core_r_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .res_o(res_o), .dbz_o(dbz_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    bit          rem;
    int          k;
    int          hold;
    logic [31:0] exp_res;
    bit          exp_dbz;
  } vec_t;

  task automatic check(input string name, input logic [N_BITS-1:0] act, input logic [N_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: integer division with truncation toward zero, results taken mod 2^N_BITS
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s, input bit rem,
                                output logic [31:0] res, output bit dbz);
    longint sa, sb, q, r;
    if (b == 0) begin
      q = -1; r = {32'd0, a}; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
      if (s) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else   begin sa = {32'd0, a}; sb = {32'd0, b}; end
      q = sa / sb;
      r = sa % sb;
    end
    res = rem ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input bit s);
    longint v;
    v = s ? longint'($signed(x)) : {32'd0, x};
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s, input bit rem,
                        input int k, input int hold, input bit spurious,
                        output logic [31:0] got_res, output bit got_dbz);
    logic [31:0] er, ma, mb, held;
    bit ed, special, done, seen_en, stable;
    int c, en, wc;
    model(a, b, s, rem, er, ed);
    ma = mag(a, s);
    mb = mag(b, s);
    special = (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    @(negedge clk);
    check("in_ready_idle", N_BITS'(in_ready_o), 1);
    in_valid_i = 1'b1; a_i = a; b_i = b; signed_i = s; rem_i = rem; out_ready_i = 1'b0;
    @(posedge clk);
    #1 in_valid_i = 1'b0; a_i = $urandom; b_i = $urandom;
    c = 0; en = 0; wc = 0; done = 0; seen_en = 0;
    while (!done && c < N_DIV_STAGE + 64) begin
      @(negedge clk);
      c++;
      core_valid_i = 1'b0;
      if (out_valid_o) done = 1;
      else if (core_en_o) begin
        en++; seen_en = 1;
        if (en == 1) begin
          check("core_n", core_n_o, ma);
          check("core_d", core_d_o, mb);
        end
        if (spurious && en == 2) begin
          core_valid_i = 1'b1; core_q_i = $urandom; core_r_i = $urandom;
        end
      end else if (seen_en) begin
        wc++;
        if (wc == k) begin
          core_valid_i = 1'b1; core_q_i = ma / mb; core_r_i = ma % mb;
        end
      end
    end
    core_valid_i = 1'b0;
    check("out_valid_seen", N_BITS'(done), 1);
    check("latency", N_BITS'(c), special ? 1 : N_DIV_STAGE + k + 1);
    check("core_en_cycles", N_BITS'(en), special ? 0 : N_DIV_STAGE);
    check("res_model", res_o, er);
    check("dbz_model", N_BITS'(dbz_o), N_BITS'(ed));
    got_res = res_o; got_dbz = dbz_o;
    held = res_o; stable = 1;
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1; a_i = $urandom; b_i = $urandom;
      @(negedge clk);
      if (res_o !== held || out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || core_en_o !== 1'b0) stable = 0;
    end
    if (hold > 0) check("hold_stable", N_BITS'(stable), 1);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk);
    #1 out_ready_i = 1'b0;
    check("ready_after_consume", N_BITS'({in_ready_o, out_valid_o}), 2'b10);
  endtask

  vec_t vecs[11];
  logic [31:0] r;
  bit d;

  initial begin
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, 1, 0,  32'd14,       1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 1'b1, 2, 0,  32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 1'b0, 3, 0,  32'hFFFFFFF2, 1'b0};
    vecs[3]  = '{32'd5,        32'd0,        1'b0, 1'b0, 1, 0,  32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{32'd5,        32'd0,        1'b0, 1'b1, 1, 0,  32'd5,        1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1, 0,  32'h80000000, 1'b0};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1, 0,  32'd0,        1'b0};
    vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 0,  32'd0,        1'b0};
    vecs[8]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 1'b1, 1, 10, 32'd2,        1'b0};
    vecs[9]  = '{32'd9,        32'd3,        1'b0, 1'b0, 1, 0,  32'd3,        1'b0};
    vecs[10] = '{32'd10,       32'd4,        1'b0, 1'b0, 4, 0,  32'd2,        1'b0};

    #2;
    check("rst_in_ready", N_BITS'(in_ready_o), 0);
    check("rst_outputs", N_BITS'({core_en_o, out_valid_o, dbz_o}), 0);
    check("rst_res", res_o | core_n_o | core_d_o, 0);
    @(negedge clk); rst_i = 1'b0;
    #1 check("post_rst_in_ready", N_BITS'(in_ready_o), 1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].rem, vecs[i].k, vecs[i].hold, 1'b0, r, d);
      check($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      check($sformatf("vec%0d_dbz", i), N_BITS'(d), N_BITS'(vecs[i].exp_dbz));
    end

    // Asynchronous reset in the middle of the enable sweep
    @(negedge clk);
    in_valid_i = 1'b1; a_i = 32'd1000; b_i = 32'd3; signed_i = 1'b0; rem_i = 1'b0;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_en", N_BITS'(core_en_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_flags", N_BITS'({in_ready_o, core_en_o, out_valid_o, dbz_o}), 0);
    check("mid_rst_data", res_o | core_n_o | core_d_o, 0);
    @(negedge clk); rst_i = 1'b0;
    run_op(32'd81, 32'd9, 1'b0, 1'b0, 1, 0, 1'b0, r, d);
    check("after_rst_81_9", r, 32'd9);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 9);
      ra = $urandom;
      rb = (sel < 3) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (rb == 0 && sel != 0) rb = 32'd1;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)), r, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
